// File: rtl/tm_pkg.sv
// Shared types and constants for the Turing machine stimulus driver.
package tm_pkg;

  localparam int DISPLAY_W = 11;
  localparam int STEP_W    = 16;

  typedef enum logic [3:0] {
    IDLE,
    FEED_HI,
    FEED_LO,
    DONE_PULSE,
    SETTLE,
    CHECK,
    STEP_HI,
    STEP_LO,
    FINISH
  } drv_state_t;

endpackage

// File: rtl/tm_word_fifo.sv
// Synchronous word FIFO holding the tape nibbles queued by the host.
module tm_word_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_d + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_d - (AW+1)'(1);
    end
  end

  // Control registers, cleared by the active-low synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tm_stimulus_driver.sv
// Replays the Next/Done button sequence of the Turing machine core from a FIFO.
module tm_stimulus_driver
  import tm_pkg::*;
#(
  parameter int DW        = 4,
  parameter int DEPTH     = 16,
  parameter int HOLD      = 4,
  parameter int MAX_STEPS = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [DW-1:0]        load_data,
  output logic                 load_ready,
  input  logic                 start,
  output logic [DW-1:0]        tm_input_data,
  output logic                 tm_next,
  output logic                 tm_done,
  input  logic                 tm_compute_done,
  input  logic [DISPLAY_W-1:0] tm_display,
  output logic                 busy,
  output logic                 finished,
  output logic                 timeout,
  output logic                 empty_err,
  output logic [DISPLAY_W-1:0] result,
  output logic [STEP_W-1:0]    step_count
);

  localparam int CW = $clog2(HOLD) + 1;
  localparam int AW = $clog2(DEPTH);

  drv_state_t           state_q, state_d;
  logic [CW-1:0]        hold_q, hold_d;
  logic [STEP_W-1:0]    step_count_q, step_count_d;
  logic                 finished_q, finished_d;
  logic                 timeout_q, timeout_d;
  logic                 empty_err_q, empty_err_d;
  logic [DISPLAY_W-1:0] result_q, result_d;
  logic                 tm_next_q, tm_next_d;
  logic                 tm_done_q, tm_done_d;
  logic                 busy_q, busy_d;
  logic                 load_ready_q, load_ready_d;
  logic [DW-1:0]        data_q, data_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]        fifo_head;
  logic [AW:0]          fifo_count, fifo_count_nx;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (v == '1) ? v : v + STEP_W'(1);
  endfunction

  assign fifo_push = load_valid && load_ready_q && !fifo_full;
  assign fifo_pop  = (state_q == FEED_HI) && (hold_q == '0);

  tm_word_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (load_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Sequencer next state, run counters and sticky status flags.
  always_comb begin
    state_d      = state_q;
    step_count_d = step_count_q;
    finished_d   = finished_q;
    timeout_d    = timeout_q;
    empty_err_d  = empty_err_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (fifo_empty) begin
            empty_err_d = 1'b1;
          end else begin
            finished_d   = 1'b0;
            timeout_d    = 1'b0;
            empty_err_d  = 1'b0;
            step_count_d = '0;
            state_d      = FEED_HI;
          end
        end
      end
      FEED_HI:    if (hold_q == '0) state_d = FEED_LO;
      FEED_LO:    if (hold_q == '0) state_d = fifo_empty ? DONE_PULSE : FEED_HI;
      DONE_PULSE: state_d = SETTLE;
      SETTLE:     if (hold_q == '0) state_d = CHECK;
      CHECK: begin
        if (tm_compute_done) begin
          state_d = FINISH;
        end else if (step_count_q == STEP_W'(MAX_STEPS)) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end else begin
          step_count_d = sat_inc(step_count_q);
          state_d      = STEP_HI;
        end
      end
      STEP_HI:    if (hold_q == '0) state_d = STEP_LO;
      STEP_LO:    if (hold_q == '0) state_d = CHECK;
      FINISH: begin
        result_d   = tm_display;
        finished_d = 1'b1;
        state_d    = IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Hold timer and registered core-facing outputs, all derived from the next state.
  always_comb begin
    hold_d = (hold_q != '0) ? hold_q - CW'(1) : hold_q;
    if (state_d != state_q) hold_d = CW'(HOLD - 1);

    fifo_count_nx = fifo_count;
    if (fifo_push)     fifo_count_nx = fifo_count + (AW+1)'(1);
    else if (fifo_pop) fifo_count_nx = fifo_count - (AW+1)'(1);

    tm_next_d    = (state_d == FEED_HI) || (state_d == STEP_HI);
    tm_done_d    = (state_d == DONE_PULSE);
    busy_d       = (state_d != IDLE);
    load_ready_d = (state_d == IDLE) && (fifo_count_nx < (AW+1)'(DEPTH));

    // Capture the head only when a press begins so the word stays put until the next one.
    data_d = data_q;
    if ((state_d == FEED_HI) && (state_q != FEED_HI)) data_d = fifo_head;
  end

  // State and output registers with active-low synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      step_count_q <= '0;
      finished_q   <= 1'b0;
      timeout_q    <= 1'b0;
      empty_err_q  <= 1'b0;
      result_q     <= '0;
      tm_next_q    <= 1'b0;
      tm_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      step_count_q <= step_count_d;
      finished_q   <= finished_d;
      timeout_q    <= timeout_d;
      empty_err_q  <= empty_err_d;
      result_q     <= result_d;
      tm_next_q    <= tm_next_d;
      tm_done_q    <= tm_done_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
      data_q       <= data_d;
    end
  end

  assign load_ready    = load_ready_q;
  assign tm_input_data = data_q;
  assign tm_next       = tm_next_q;
  assign tm_done       = tm_done_q;
  assign busy          = busy_q;
  assign finished      = finished_q;
  assign timeout       = timeout_q;
  assign empty_err     = empty_err_q;
  assign result        = result_q;
  assign step_count    = step_count_q;

endmodule

// File: tb/tb_tm_stimulus_driver.sv
// Bench for tm_stimulus_driver: a stub core plus a timeline model of each run.
module tb_tm_stimulus_driver;

  localparam int DW        = 4;
  localparam int DEPTH     = 16;
  localparam int HOLD      = 4;
  localparam int MAX_STEPS = 7;
  localparam int NEVER     = 1000000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic          start = 1'b0;
  logic [DW-1:0] tm_input_data;
  logic          tm_next, tm_done;
  logic          tm_compute_done = 1'b0;
  logic [10:0]   tm_display = '0;
  logic          busy, finished, timeout, empty_err;
  logic [10:0]   result;
  logic [15:0]   step_count;

  int checks = 0;
  int errors = 0;

  tm_stimulus_driver #(.DW(DW), .DEPTH(DEPTH), .HOLD(HOLD), .MAX_STEPS(MAX_STEPS)) dut (
    .clock           (clock),
    .reset           (reset),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .start           (start),
    .tm_input_data   (tm_input_data),
    .tm_next         (tm_next),
    .tm_done         (tm_done),
    .tm_compute_done (tm_compute_done),
    .tm_display      (tm_display),
    .busy            (busy),
    .finished        (finished),
    .timeout         (timeout),
    .empty_err       (empty_err),
    .result          (result),
    .step_count      (step_count)
  );

  always #5 clock = ~clock;

  // Monitor / stub core state
  int            cyc = 0, start_cyc = 0, busy_fall_cyc = 0;
  int            rise_q[$];
  int            len_q[$];
  logic [DW-1:0] pdata_q[$];
  int            done_q[$];
  int            dlen_q[$];
  int            both_hi = 0, data_bad = 0, steps_seen = 0, cd_target = NEVER;
  bit            after_done = 1'b0;
  logic          prev_next = 1'b0, prev_done = 1'b0, prev_busy = 1'b0;
  int            cur_rise = 0, dstart = 0;
  logic [DW-1:0] cur_data = '0;

  logic [DW-1:0] model_fifo[$];
  logic [DW-1:0] exp_words[$];

  // Record press waveforms and play the core: compute_done after cd_target step presses.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (start === 1'b1 && reset === 1'b1) begin
      start_cyc = cyc;
      rise_q.delete(); len_q.delete(); pdata_q.delete(); done_q.delete(); dlen_q.delete();
      after_done = 1'b0; steps_seen = 0; both_hi = 0; data_bad = 0;
    end
    if (tm_next === 1'b1 && tm_done === 1'b1) both_hi++;
    if (tm_next === 1'b1 && prev_next !== 1'b1) begin
      cur_rise = cyc;
      cur_data = tm_input_data;
    end
    if (tm_next === 1'b1 && prev_next === 1'b1 && tm_input_data !== cur_data) data_bad++;
    if (tm_next !== 1'b1 && prev_next === 1'b1) begin
      rise_q.push_back(cur_rise);
      len_q.push_back(cyc - cur_rise);
      pdata_q.push_back(cur_data);
      if (after_done) steps_seen++;
    end
    if (tm_done === 1'b1 && prev_done !== 1'b1) begin
      done_q.push_back(cyc);
      dstart = cyc;
      after_done = 1'b1;
      steps_seen = 0;
    end
    if (tm_done !== 1'b1 && prev_done === 1'b1) dlen_q.push_back(cyc - dstart);
    if (busy !== 1'b1 && prev_busy === 1'b1) busy_fall_cyc = cyc;
    tm_compute_done = after_done && (steps_seen >= cd_target);
    prev_next = tm_next;
    prev_done = tm_done;
    prev_busy = busy;
  end

  task automatic push_word(input logic [DW-1:0] w);
    logic exp_ready;
    @(negedge clock);
    exp_ready = (model_fifo.size() < DEPTH);
    checks++;
    if (load_ready !== exp_ready) begin
      errors++;
      $display("FAIL push_ready: load_ready=%b expected %b with %0d words queued", load_ready, exp_ready, model_fifo.size());
    end
    load_valid = 1'b1;
    load_data  = w;
    if (exp_ready) model_fifo.push_back(w);
  endtask

  task automatic end_push();
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic launch(input int target, input logic [10:0] disp);
    cd_target  = target;
    tm_display = disp;
    exp_words  = model_fifo;
    model_fifo.delete();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  // Full run against the press timeline implied by N queued words and the stub's step target.
  task automatic run_scenario(input string name, input int target, input logic [10:0] disp);
    int n, k, total, exp_rise, exp_done, exp_end;
    logic exp_to;
    n        = model_fifo.size();
    k        = (target < MAX_STEPS) ? target : MAX_STEPS;
    exp_to   = (target > MAX_STEPS);
    total    = n + k;
    launch(target, disp);
    wait_idle(name);
    exp_done = start_cyc + 2 * HOLD * n;
    exp_end  = exp_done + HOLD + 3 + (2 * HOLD + 1) * k;
    checks++;
    if (rise_q.size() != total) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d pulses, expected %0d", name, rise_q.size(), total);
    end
    for (int i = 0; i < total && i < rise_q.size(); i++) begin
      exp_rise = (i < n) ? start_cyc + 2 * HOLD * i
                         : exp_done + HOLD + 2 + (2 * HOLD + 1) * (i - n);
      checks++;
      if (rise_q[i] != exp_rise || len_q[i] != HOLD || (i < n && pdata_q[i] !== exp_words[i])) begin
        errors++;
        $display("FAIL %s_pulse%0d: rise %0d len %0d data %h, expected rise %0d len %0d data %h",
                 name, i, rise_q[i], len_q[i], pdata_q[i], exp_rise, HOLD,
                 (i < n) ? exp_words[i] : pdata_q[i]);
      end
    end
    checks++;
    if (done_q.size() != 1 || dlen_q.size() != 1 || done_q[0] != exp_done || dlen_q[0] != 1) begin
      errors++;
      $display("FAIL %s_done: %0d done pulses, first at %0d width %0d, expected 1 at %0d width 1",
               name, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1,
               (dlen_q.size() > 0) ? dlen_q[0] : -1, exp_done);
    end
    checks++;
    if (step_count !== 16'(k)) begin
      errors++;
      $display("FAIL %s_step_count: got %0d, expected %0d", name, step_count, k);
    end
    checks++;
    if (timeout !== exp_to || finished !== 1'b1 || empty_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags: timeout=%b finished=%b empty_err=%b, expected %b 1 0",
               name, timeout, finished, empty_err, exp_to);
    end
    checks++;
    if (result !== disp) begin
      errors++;
      $display("FAIL %s_result: got %h, expected %h", name, result, disp);
    end
    checks++;
    if (busy_fall_cyc != exp_end || both_hi != 0 || data_bad != 0) begin
      errors++;
      $display("FAIL %s_timing: busy fell at %0d (expected %0d), next+done overlaps %0d, data glitches %0d",
               name, busy_fall_cyc, exp_end, both_hi, data_bad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({load_ready, tm_next, tm_done, busy, finished, timeout, empty_err} !== 7'b0 ||
        tm_input_data !== '0 || result !== '0 || step_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags %b data %h result %h steps %0d, expected all zero",
               {load_ready, tm_next, tm_done, busy, finished, timeout, empty_err},
               tm_input_data, result, step_count);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: load_ready=%b busy=%b, expected 1 0", load_ready, busy);
    end
  endtask

  task automatic test_feed_sequence();
    push_word(4'h1);
    push_word(4'h0);
    push_word(4'h1);
    end_push();
    run_scenario("feed101", NEVER, 11'h3C1);
  endtask

  task automatic test_compute_done();
    for (int i = 0; i < 3; i++) push_word(4'($urandom_range(0, 15)));
    end_push();
    run_scenario("cdone", 5, 11'h2A5);
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < DEPTH + 1; i++) push_word(4'($urandom_range(0, 15)));
    end_push();
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: load_ready=%b with full FIFO, expected 0", load_ready);
    end
    run_scenario("full", 0, 11'($urandom_range(0, 2047)));
  endtask

  task automatic test_random_runs();
    int n;
    repeat (4) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) push_word(4'($urandom_range(0, 15)));
      end_push();
      run_scenario("rand", int'($urandom_range(0, 9)), 11'($urandom_range(0, 2047)));
    end
  endtask

  task automatic test_drop_and_empty();
    int bad, n, quiet;
    push_word(4'h9);
    push_word(4'h6);
    end_push();
    launch(2, 11'h011);
    bad = 0;
    n   = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clock);
      load_valid = 1'b1;
      load_data  = 4'($urandom_range(0, 15));
      if (busy === 1'b1 && load_ready !== 1'b0) bad++;
      n++;
    end
    load_valid = 1'b0;
    wait_idle("drop");
    checks++;
    if (bad != 0 || step_count !== 16'd2) begin
      errors++;
      $display("FAIL drop_while_busy: load_ready high %0d cycles, steps %0d, expected 0 and 2", bad, step_count);
    end
    launch(NEVER, 11'h000);
    checks++;
    if (empty_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_start: empty_err=%b busy=%b, expected 1 0", empty_err, busy);
    end
    quiet = 0;
    repeat (10) begin
      @(negedge clock);
      if (busy !== 1'b0 || tm_next !== 1'b0 || tm_done !== 1'b0) quiet++;
    end
    checks++;
    if (quiet != 0 || rise_q.size() != 0) begin
      errors++;
      $display("FAIL empty_quiet: %0d active cycles, %0d pulses, expected 0 0", quiet, rise_q.size());
    end
  endtask

  task automatic test_reset_flags();
    for (int i = 0; i < 3; i++) push_word(4'($urandom_range(1, 15)));
    end_push();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (finished !== 1'b0 || empty_err !== 1'b0 || result !== '0 || step_count !== '0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: finished=%b empty_err=%b result=%h steps=%0d ready=%b, expected zeros",
               finished, empty_err, result, step_count, load_ready);
    end
    reset = 1'b1;
    model_fifo.delete();
    @(negedge clock);
    launch(NEVER, 11'h000);
    checks++;
    if (empty_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo_empty: empty_err=%b busy=%b, expected 1 0", empty_err, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    push_word(4'hA);
    push_word(4'h5);
    end_push();
    launch(NEVER, 11'h155);
    n = 0;
    while (!(after_done && tm_next === 1'b1) && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!(after_done && tm_next === 1'b1) || step_count !== 16'd1) begin
      errors++;
      $display("FAIL midrun_reach_step: tm_next=%b steps=%0d after %0d cycles, expected 1 and 1", tm_next, step_count, n);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({tm_next, tm_done, busy, finished, timeout, empty_err, load_ready} !== 7'b0 || step_count !== '0) begin
      errors++;
      $display("FAIL midrun_reset: next/done/busy/fin/to/eerr/ready=%b steps=%0d, expected zeros",
               {tm_next, tm_done, busy, finished, timeout, empty_err, load_ready}, step_count);
    end
    reset = 1'b1;
    model_fifo.delete();
    @(negedge clock);
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || tm_next !== 1'b0) begin
      errors++;
      $display("FAIL midrun_recover: ready=%b busy=%b next=%b, expected 1 0 0", load_ready, busy, tm_next);
    end
  endtask

  initial begin
    test_reset();
    test_feed_sequence();
    test_compute_done();
    test_fifo_full();
    test_random_runs();
    test_drop_and_empty();
    test_reset_flags();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
